// File: rtl/sobel_pkg.sv
// Constants, FSM encodings and helpers shared by the sobel window sequencing logic.
// Coordinate widths cover 640x480 frames.
package sobel_pkg;

   localparam int WIN_K    = 5;
   localparam int WIN_HALF = WIN_K / 2;
   localparam int XW       = 11;
   localparam int YW       = 10;
   localparam int CW       = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FILL   = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Shifts needed before a pixel reaches the centre tap of a k x k window.
   function automatic int lag_of(input int cols, input int k);
      return (k / 2) * cols + (k / 2);
   endfunction

   function automatic logic on_border(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                      input int cols, input int rows, input int half);
      return (x < XW'(half)) || (x >= XW'(cols - half)) ||
             (y < YW'(half)) || (y >= YW'(rows - half));
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: x wraps at the end of a line and bumps y, y wraps at frame end.
// A clear together with a step leaves the counter at the position after (0,0).
module raster_counter
   import sobel_pkg::*;
#(
   parameter int COLS = 640,
   parameter int ROWS = 480
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);

   logic [XW-1:0] base_x;
   logic [YW-1:0] base_y;

   assign base_x = clear ? '0 : x;
   assign base_y = clear ? '0 : y;
   assign last   = (x == XW'(COLS - 1)) && (y == YW'(ROWS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (clear || step) begin
         if (!step) begin
            x <= base_x;
            y <= base_y;
         end else if (base_x == XW'(COLS - 1)) begin
            x <= '0;
            y <= (base_y == YW'(ROWS - 1)) ? '0 : base_y + 1'b1;
         end else begin
            x <= base_x + 1'b1;
            y <= base_y;
         end
      end
   end

endmodule

// File: rtl/window_stream_ctrl.sv
// Sequences the line buffer for the 5x5 sobel window: fill, stream, zero-fill drain,
// and tags each complete window with its centre coordinate and a border flag.
module window_stream_ctrl
   import sobel_pkg::*;
#(
   parameter int COLS = 640,
   parameter int ROWS = 480,
   parameter int K    = WIN_K
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          frame_start,
   input  logic          pix_valid,
   output logic          shift_en,
   output logic          fill_zero,
   output logic          win_valid,
   output logic [XW-1:0] win_x,
   output logic [YW-1:0] win_y,
   output logic          border,
   output logic          frame_done,
   output logic          resync,
   output logic          overrun
);

   localparam int HALF = K / 2;
   localparam int LAG  = lag_of(COLS, K);

   logic [2:0]    state;
   logic [CW-1:0] shift_cnt;
   logic          start;
   logic          shift_c;
   logic          in_step;
   logic          centre_step;
   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic          in_last;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic          centre_last;
   logic          unused_in;

   assign start     = frame_start && pix_valid;
   assign unused_in = ^{in_x, in_y};

   // A qualifying start pixel always begins a new frame, so it never produces a window.
   always_comb begin
      shift_c = 1'b0;
      case (state)
         ST_IDLE, ST_DONE:    shift_c = start;
         ST_FILL, ST_STREAM:  shift_c = pix_valid;
         ST_DRAIN:            shift_c = 1'b1;
         default:             shift_c = 1'b0;
      endcase
      in_step     = start || (pix_valid && ((state == ST_FILL) || (state == ST_STREAM)));
      centre_step = shift_c && !start && ((state == ST_STREAM) || (state == ST_DRAIN));
   end

   assign shift_en   = shift_c && !reset;
   assign fill_zero  = (state == ST_DRAIN) && !start;
   assign frame_done = (state == ST_DONE);

   raster_counter #(.COLS(COLS), .ROWS(ROWS)) u_in_pos (
      .clock (clock),
      .reset (reset),
      .clear (start),
      .step  (in_step),
      .x     (in_x),
      .y     (in_y),
      .last  (in_last)
   );

   raster_counter #(.COLS(COLS), .ROWS(ROWS)) u_centre_pos (
      .clock (clock),
      .reset (reset),
      .clear (start),
      .step  (centre_step),
      .x     (cx),
      .y     (cy),
      .last  (centre_last)
   );

   // The drain ends on the shift that emits the final centre, which is exactly LAG shifts in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shift_cnt <= '0;
         win_valid <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
         border    <= 1'b0;
         resync    <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         resync    <= start && (state != ST_IDLE);
         overrun   <= (state == ST_DRAIN) && pix_valid && !start;
         win_valid <= centre_step;
         border    <= centre_step && on_border(cx, cy, COLS, ROWS, HALF);
         if (centre_step) begin
            win_x <= cx;
            win_y <= cy;
         end
         if (start) begin
            state     <= ST_FILL;
            shift_cnt <= CW'(1);
         end else begin
            case (state)
               ST_FILL: begin
                  if (pix_valid) begin
                     shift_cnt <= shift_cnt + 1'b1;
                     if (shift_cnt + 1'b1 == CW'(LAG)) state <= ST_STREAM;
                  end
               end
               ST_STREAM: if (pix_valid && in_last) state <= ST_DRAIN;
               ST_DRAIN:  if (centre_last) state <= ST_DONE;
               ST_DONE:   state <= ST_IDLE;
               default:   state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Directed bench for window_stream_ctrl on an 8x6 frame with a 5x5 window (LAG = 18).
// Each scenario task drives the DUT and compares against hand-derived expectations.
module tb_window_stream_ctrl;

   logic        clock;
   logic        reset;
   logic        frame_start;
   logic        pix_valid;
   logic        shift_en;
   logic        fill_zero;
   logic        win_valid;
   logic [10:0] win_x;
   logic [9:0]  win_y;
   logic        border;
   logic        frame_done;
   logic        resync;
   logic        overrun;

   int checks;
   int failures;

   window_stream_ctrl #(.COLS(8), .ROWS(6), .K(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .shift_en    (shift_en),
      .fill_zero   (fill_zero),
      .win_valid   (win_valid),
      .win_x       (win_x),
      .win_y       (win_y),
      .border      (border),
      .frame_done  (frame_done),
      .resync      (resync),
      .overrun     (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic bit exp_border(input int x, input int y);
      return (x < 2) || (x >= 6) || (y < 2) || (y >= 4);
   endfunction

   // Drives one frame and gathers statistics; the scenario tasks judge them.
   task automatic run_frame(input int gap_pct, input int abort_at, input int poke_at,
                            output int strobes, output int border0, output int fz_cycles,
                            output int done_pulses, output int resync_pulses,
                            output int overrun_pulses, output int overrun_delay,
                            output int coord_err, output int orphan_err,
                            output int first_shift, output int first_x, output int first_y,
                            output int first_border, output int drain_noshift,
                            output bit timed_out);
      int  sent, idle, cur_idle, exp_x, exp_y, shifts_since, post_done, total;
      bit  prev_shift, want_first;
      strobes = 0; border0 = 0; fz_cycles = 0; done_pulses = 0; resync_pulses = 0;
      overrun_pulses = 0; overrun_delay = -1; coord_err = 0; orphan_err = 0;
      first_shift = -1; first_x = -1; first_y = -1; first_border = -1; drain_noshift = 0;
      timed_out = 1'b1;
      sent = 0; idle = 0; exp_x = 0; exp_y = 0; shifts_since = 0; post_done = -1;
      prev_shift = 1'b0; want_first = 1'b1;
      total = (abort_at >= 0) ? abort_at + 48 : 48;
      for (int cyc = 0; cyc < 800; cyc++) begin
         frame_start = 1'b0;
         pix_valid   = 1'b0;
         cur_idle    = -1;
         if (sent < total) begin
            if (sent == 0 || sent == abort_at) begin
               frame_start = 1'b1;
               pix_valid   = 1'b1;
            end else begin
               pix_valid = ($urandom_range(99) >= gap_pct);
            end
         end else begin
            cur_idle = idle;
            if (idle == poke_at) pix_valid = 1'b1;
            idle++;
         end
         @(negedge clock);
         if (win_valid) begin
            strobes++;
            if (!prev_shift) orphan_err++;
            if (win_x !== 11'(exp_x) || win_y !== 10'(exp_y)) coord_err++;
            if (border !== exp_border(exp_x, exp_y)) coord_err++;
            if (border === 1'b0) border0++;
            if (want_first) begin
               first_shift  = shifts_since;
               first_x      = int'(win_x);
               first_y      = int'(win_y);
               first_border = int'(border);
               want_first   = 1'b0;
            end
            if (exp_x == 7) begin
               exp_x = 0;
               exp_y = (exp_y == 5) ? 0 : exp_y + 1;
            end else begin
               exp_x++;
            end
         end
         if (fill_zero) begin
            fz_cycles++;
            if (!shift_en) drain_noshift++;
         end
         if (frame_done) done_pulses++;
         if (resync) resync_pulses++;
         if (overrun) begin
            overrun_pulses++;
            overrun_delay = cur_idle - poke_at;
         end
         if (frame_start && pix_valid) begin
            exp_x = 0; exp_y = 0; shifts_since = 0; want_first = 1'b1;
         end
         if (shift_en) shifts_since++;
         if (pix_valid && sent < total) sent++;
         prev_shift = shift_en;
         if (post_done >= 0) post_done++;
         if (frame_done && post_done < 0) post_done = 0;
         @(posedge clock);
         #1;
         if (post_done == 3) begin
            timed_out = 1'b0;
            break;
         end
      end
      frame_start = 1'b0;
      pix_valid   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
      @(negedge clock);
      checks++; if (shift_en !== 1'b0 || fill_zero !== 1'b0 || frame_done !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_comb: shift_en=%b fill_zero=%b frame_done=%b want 000", shift_en, fill_zero, frame_done); end
      checks++; if (win_valid !== 1'b0 || win_x !== 11'd0 || win_y !== 10'd0 || border !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_win: valid=%b x=%0d y=%0d border=%b want all 0", win_valid, win_x, win_y, border); end
      checks++; if (resync !== 1'b0 || overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_pulses: resync=%b overrun=%b want 00", resync, overrun); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_idle_ignore();
      pix_valid = 1'b1; frame_start = 1'b0;
      @(negedge clock);
      checks++; if (shift_en !== 1'b0) begin
         failures++; $display("[TB] FAIL idle_pix_no_shift: shift_en=%b want 0", shift_en); end
      @(posedge clock); #1;
      pix_valid = 1'b0; frame_start = 1'b1;
      @(negedge clock);
      checks++; if (shift_en !== 1'b0) begin
         failures++; $display("[TB] FAIL start_no_pix_no_shift: shift_en=%b want 0", shift_en); end
      @(posedge clock); #1;
      frame_start = 1'b0;
      @(negedge clock);
      checks++; if (win_valid !== 1'b0 || fill_zero !== 1'b0 || resync !== 1'b0) begin
         failures++; $display("[TB] FAIL idle_quiet: win_valid=%b fill_zero=%b resync=%b want 000", win_valid, fill_zero, resync); end
      @(posedge clock); #1;
   endtask

   task automatic test_continuous();
      int st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns;
      bit to;
      run_frame(0, -1, -1, st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL cont_timeout: frame_done never seen"); end
      checks++; if (fs !== 19) begin failures++; $display("[TB] FAIL cont_first_latency: shifts before first strobe=%0d want 19", fs); end
      checks++; if (fx !== 0 || fy !== 0 || fb !== 1) begin
         failures++; $display("[TB] FAIL cont_first_window: (%0d,%0d) border=%0d want (0,0) border=1", fx, fy, fb); end
      checks++; if (st !== 48) begin failures++; $display("[TB] FAIL cont_strobes: got %0d want 48", st); end
      checks++; if (ce !== 0) begin failures++; $display("[TB] FAIL cont_coords: %0d coordinate/border errors want 0", ce); end
      checks++; if (b0 !== 8) begin failures++; $display("[TB] FAIL cont_border_map: interior windows=%0d want 8", b0); end
      checks++; if (fz !== 18 || dns !== 0) begin
         failures++; $display("[TB] FAIL cont_drain: fill_zero cycles=%0d unshifted=%0d want 18/0", fz, dns); end
      checks++; if (dn !== 1) begin failures++; $display("[TB] FAIL cont_frame_done: pulses=%0d want 1", dn); end
      checks++; if (rs !== 0 || ov !== 0 || oe !== 0) begin
         failures++; $display("[TB] FAIL cont_spurious: resync=%0d overrun=%0d orphan=%0d want 0/0/0", rs, ov, oe); end
   endtask

   task automatic test_gaps();
      int st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns;
      bit to;
      run_frame(50, -1, -1, st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL gap_timeout: frame_done never seen"); end
      checks++; if (oe !== 0) begin failures++; $display("[TB] FAIL gap_orphan: strobes without prior shift=%0d want 0", oe); end
      checks++; if (st !== 48 || ce !== 0) begin
         failures++; $display("[TB] FAIL gap_sequence: strobes=%0d coord errors=%0d want 48/0", st, ce); end
      checks++; if (fs !== 19 || b0 !== 8 || dn !== 1) begin
         failures++; $display("[TB] FAIL gap_frame: first=%0d interior=%0d done=%0d want 19/8/1", fs, b0, dn); end
   endtask

   task automatic test_resync();
      int st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns;
      bit to;
      run_frame(0, 30, -1, st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL resync_timeout: frame_done never seen"); end
      checks++; if (rs !== 1) begin failures++; $display("[TB] FAIL resync_pulse: pulses=%0d want 1", rs); end
      checks++; if (dn !== 1) begin failures++; $display("[TB] FAIL resync_done: frame_done pulses=%0d want 1", dn); end
      checks++; if (fs !== 19 || fx !== 0 || fy !== 0) begin
         failures++; $display("[TB] FAIL resync_restart: shifts=%0d first=(%0d,%0d) want 19 (0,0)", fs, fx, fy); end
      checks++; if (st !== 60 || ce !== 0 || oe !== 0) begin
         failures++; $display("[TB] FAIL resync_strobes: strobes=%0d coord=%0d orphan=%0d want 60/0/0", st, ce, oe); end
   endtask

   task automatic test_overrun();
      int st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns;
      bit to;
      run_frame(0, -1, 5, st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns, to);
      checks++; if (to) begin failures++; $display("[TB] FAIL ovr_timeout: frame_done never seen"); end
      checks++; if (ov !== 1 || ovd !== 1) begin
         failures++; $display("[TB] FAIL ovr_pulse: pulses=%0d delay=%0d want 1/1", ov, ovd); end
      checks++; if (fz !== 18 || dns !== 0) begin
         failures++; $display("[TB] FAIL ovr_drain: fill_zero cycles=%0d unshifted=%0d want 18/0", fz, dns); end
      checks++; if (st !== 48 || ce !== 0 || dn !== 1) begin
         failures++; $display("[TB] FAIL ovr_frame: strobes=%0d coord=%0d done=%0d want 48/0/1", st, ce, dn); end
   endtask

   task automatic test_reset_mid_stream();
      int st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns;
      bit to;
      frame_start = 1'b1; pix_valid = 1'b1;
      @(posedge clock); #1;
      frame_start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clock); #1;
      end
      @(negedge clock);
      checks++; if (win_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL mid_stream_active: win_valid=%b want 1", win_valid); end
      #1 reset = 1'b1;
      #1;
      checks++; if (shift_en !== 1'b0 || fill_zero !== 1'b0 || win_valid !== 1'b0 || border !== 1'b0 ||
                    win_x !== 11'd0 || win_y !== 10'd0 || frame_done !== 1'b0 || resync !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_reset_outputs: shift=%b fz=%b valid=%b border=%b x=%0d y=%0d done=%b resync=%b ovr=%b want all 0",
                  shift_en, fill_zero, win_valid, border, win_x, win_y, frame_done, resync, overrun);
      end
      pix_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      run_frame(0, -1, -1, st, b0, fz, dn, rs, ov, ovd, ce, oe, fs, fx, fy, fb, dns, to);
      checks++; if (to || st !== 48 || ce !== 0 || dn !== 1 || fs !== 19) begin
         failures++; $display("[TB] FAIL post_reset_frame: timeout=%0b strobes=%0d coord=%0d done=%0d first=%0d want 0/48/0/1/19",
                              to, st, ce, dn, fs);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
      test_reset();
      test_idle_ignore();
      test_continuous();
      test_gaps();
      test_resync();
      test_overrun();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
